// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a word-organised data memory.
// Loads extract and extend bytes or halves; sub-word stores do a two-cycle read-modify-write.
module load_store_unit #(
  parameter int MEM_WORDS = 256,
  parameter int WIDX_W    = $clog2(MEM_WORDS)
) (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic        i_Req,
  input  logic        i_We,
  input  logic [2:0]  i_Funct3,
  input  logic [31:0] i_Addr,
  input  logic [31:0] i_wData,
  output logic        o_Busy,
  output logic        o_Done,
  output logic [31:0] o_rData,
  output logic        o_Fault,
  output logic [31:0] o_MemAddr,
  output logic        o_MemWe,
  output logic [31:0] o_MemWData,
  input  logic [31:0] i_MemRData
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WRITE,
    S_DONE
  } state_t;

  state_t      state;
  logic        req_we;
  logic [2:0]  req_f3;
  logic [1:0]  req_lane;
  logic [15:0] req_wdata;

  logic        f3_bad;
  logic        misaligned;
  logic        out_of_range;
  logic        fault;
  logic [31:0] word_idx;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_val;
  logic [31:0] merged;

  assign o_Busy = (state != S_IDLE);

  always_comb begin
    f3_bad = 1'b0;
    if (i_We) begin
      f3_bad = (i_Funct3 >= 3'd3);
    end else begin
      f3_bad = (i_Funct3 == 3'd3) || (i_Funct3 == 3'd6) || (i_Funct3 == 3'd7);
    end
    misaligned = 1'b0;
    case (i_Funct3[1:0])
      2'b01:   misaligned = i_Addr[0];
      2'b10:   misaligned = (i_Addr[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
    out_of_range = |i_Addr[31:WIDX_W+2];
    fault        = f3_bad || misaligned || out_of_range;
    word_idx     = {{(32-WIDX_W){1'b0}}, i_Addr[WIDX_W+1:2]};
  end

  // Lane selection uses only the latched request; i_MemRData reflects o_MemAddr.
  always_comb begin
    rd_byte  = i_MemRData[{req_lane, 3'b000} +: 8];
    rd_half  = i_MemRData[{req_lane[1], 4'b0000} +: 16];
    load_val = i_MemRData;
    case (req_f3)
      3'd0:    load_val = {{24{rd_byte[7]}}, rd_byte};
      3'd4:    load_val = {24'h000000, rd_byte};
      3'd1:    load_val = {{16{rd_half[15]}}, rd_half};
      3'd5:    load_val = {16'h0000, rd_half};
      default: load_val = i_MemRData;
    endcase
    merged = i_MemRData;
    if (req_f3[0] == 1'b0) begin
      merged[{req_lane, 3'b000} +: 8] = req_wdata[7:0];
    end else begin
      merged[{req_lane[1], 4'b0000} +: 16] = req_wdata;
    end
  end

  // SW write strobe is registered on accept so the write lands in the ACCESS cycle.
  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      state      <= S_IDLE;
      req_we     <= 1'b0;
      req_f3     <= '0;
      req_lane   <= '0;
      req_wdata  <= '0;
      o_Done     <= 1'b0;
      o_Fault    <= 1'b0;
      o_rData    <= '0;
      o_MemAddr  <= '0;
      o_MemWe    <= 1'b0;
      o_MemWData <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_Req) begin
            req_we    <= i_We;
            req_f3    <= i_Funct3;
            req_lane  <= i_Addr[1:0];
            req_wdata <= i_wData[15:0];
            if (fault) begin
              o_Done  <= 1'b1;
              o_Fault <= 1'b1;
              state   <= S_DONE;
            end else begin
              o_MemAddr <= word_idx;
              if (i_We && (i_Funct3 == 3'd2)) begin
                o_MemWe    <= 1'b1;
                o_MemWData <= i_wData;
              end
              state <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          if (!req_we) begin
            o_rData   <= load_val;
            o_MemAddr <= '0;
            o_Done    <= 1'b1;
            state     <= S_DONE;
          end else if (req_f3 == 3'd2) begin
            o_MemWe    <= 1'b0;
            o_MemWData <= '0;
            o_MemAddr  <= '0;
            o_Done     <= 1'b1;
            state      <= S_DONE;
          end else begin
            o_MemWe    <= 1'b1;
            o_MemWData <= merged;
            state      <= S_WRITE;
          end
        end
        S_WRITE: begin
          o_MemWe    <= 1'b0;
          o_MemWData <= '0;
          o_MemAddr  <= '0;
          o_Done     <= 1'b1;
          state      <= S_DONE;
        end
        S_DONE: begin
          o_Done  <= 1'b0;
          o_Fault <= 1'b0;
          o_rData <= '0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
